dma_cfg_master: RTL and testbench

DMA_CFG_MASTER -- requirements
Module: dma_cfg_master

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_cfg_master_if.sv | 20 ++
 rtl/dma_cfg_master.sv | 192 +++++++++++++++++++
 tb/tb_dma_cfg_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA configuration master: register offsets of the
// DMA responder and the master's FSM state encoding.
// No ports (package).
package dma_pkg;

    localparam int unsigned REG_W = 32;

    // Responder register map
    localparam logic [REG_W-1:0] REG_INTR     = 32'h0000_0400;
    localparam logic [REG_W-1:0] REG_CTRL     = 32'h0000_0404;
    localparam logic [REG_W-1:0] REG_IO_ADDR  = 32'h0000_0408;
    localparam logic [REG_W-1:0] REG_MEM_ADDR = 32'h0000_040C;

    typedef enum logic [3:0] {
        IDLE,
        WR_IO,
        WR_MEM,
        WR_CTRL,
        RD_REQ,
        RD_WAIT,
        GAP,
        CLR,
        FIN
    } dma_state_e;

endpackage

// File: rtl/dma_cfg_master_if.sv
// Register-bus interface between the DMA configuration master and the DMA
// register responder.
//   addr  : beat address            (master -> slave)
//   wr_en : 1 = write, 0 = read     (master -> slave)
//   valid : one-cycle beat strobe   (master -> slave)
//   wdata : write data              (master -> slave)
//   rdata : read data, valid the cycle after a read beat (slave -> master)
interface dma_cfg_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  valid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output addr, output wr_en, output valid, output wdata, input rdata);
    modport slave  (input addr, input wr_en, input valid, input wdata, output rdata);
endinterface

// File: rtl/dma_cfg_master.sv
// DMA configuration master: programs IO address, memory address and control
// word into the DMA responder, polls the interrupt status register until it
// reads non-zero, clears it, and reports completion.
// Optional poll timeout compiled in with DMA_CFG_TIMEOUT_EN.
// Ports:
//   clk, reset (async, active low)
//   start, io_addr_in, mem_addr_in, ctrl_in : job request and its parameters
//   busy, done, error, intr_status          : job status (all registered)
//   bus                                     : register-bus master modport
module dma_cfg_master
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] io_addr_in,
    input  logic [DATA_WIDTH-1:0] mem_addr_in,
    input  logic [DATA_WIDTH-1:0] ctrl_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] intr_status,
    dma_cfg_master_if.master      bus
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    if (POLL_GAP < 1 || POLL_LIMIT < 1) begin : g_bad_params
        $error("dma_cfg_master: POLL_GAP and POLL_LIMIT must be >= 1");
    end

    dma_state_e            state, state_next;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q, ctrl_q;
    logic                  accept_c;
    logic                  timed_out_c;

    logic                  valid_d, wr_en_d, busy_d, done_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, intr_d;

    assign accept_c = (state == IDLE) && start;

`ifdef DMA_CFG_TIMEOUT_EN
    localparam int unsigned RD_W = $clog2(POLL_LIMIT + 1);
    logic [RD_W-1:0] rd_cnt;

    // Status reads issued in the current job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 rd_cnt <= '0;
        else if (accept_c)          rd_cnt <= '0;
        else if (state == RD_REQ)   rd_cnt <= rd_cnt + RD_W'(1);
    end

    assign timed_out_c = (rd_cnt == RD_W'(POLL_LIMIT));

    // Error only on the RD_WAIT -> FIN shortcut, so it coincides with done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) error <= 1'b0;
        else        error <= (state == RD_WAIT) && (state_next == FIN);
    end
`else
    assign timed_out_c = 1'b0;
    assign error       = 1'b0;
`endif

    // State register and gap counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        gap_cnt_d  = gap_cnt;
        case (state)
            IDLE:    if (start) state_next = WR_IO;
            WR_IO:   state_next = WR_MEM;
            WR_MEM:  state_next = WR_CTRL;
            WR_CTRL: state_next = RD_REQ;
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: begin
                if (bus.rdata != '0) begin
                    state_next = CLR;
                end else if (timed_out_c) begin
                    state_next = FIN;
                end else begin
                    state_next = GAP;
                    gap_cnt_d  = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_next = RD_REQ;
                else                                 gap_cnt_d  = gap_cnt + GAP_W'(1);
            end
            CLR:     state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next state so each registered output lines up
    // with the state it belongs to; bus fields hold when no beat is issued.
    always_comb begin
        valid_d = 1'b0;
        wr_en_d = bus.wr_en;
        addr_d  = bus.addr;
        wdata_d = bus.wdata;
        busy_d  = (state_next != IDLE);
        done_d  = (state_next == FIN);
        intr_d  = intr_status;
        case (state_next)
            WR_IO: begin
                // io address is taken straight from the input on accept; the
                // wdata register holds it for the beat
                valid_d = 1'b1;
                wr_en_d = 1'b1;
                addr_d  = ADDR_WIDTH'(REG_IO_ADDR);
                wdata_d = io_addr_in;
            end
            WR_MEM: begin
                valid_d = 1'b1;
                wr_en_d = 1'b1;
                addr_d  = ADDR_WIDTH'(REG_MEM_ADDR);
                wdata_d = mem_q;
            end
            WR_CTRL: begin
                valid_d = 1'b1;
                wr_en_d = 1'b1;
                addr_d  = ADDR_WIDTH'(REG_CTRL);
                wdata_d = ctrl_q;
            end
            RD_REQ: begin
                valid_d = 1'b1;
                wr_en_d = 1'b0;
                addr_d  = ADDR_WIDTH'(REG_INTR);
            end
            CLR: begin
                valid_d = 1'b1;
                wr_en_d = 1'b1;
                addr_d  = ADDR_WIDTH'(REG_INTR);
                wdata_d = '0;
            end
            default: ;
        endcase
        if ((state == RD_WAIT) && (bus.rdata != '0)) intr_d = bus.rdata;
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.valid   <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.addr    <= '0;
            bus.wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            intr_status <= '0;
        end else begin
            bus.valid   <= valid_d;
            bus.wr_en   <= wr_en_d;
            bus.addr    <= addr_d;
            bus.wdata   <= wdata_d;
            busy        <= busy_d;
            done        <= done_d;
            intr_status <= intr_d;
        end
    end

    // Job parameters captured on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q  <= '0;
            ctrl_q <= '0;
        end else if (accept_c) begin
            mem_q  <= mem_addr_in;
            ctrl_q <= ctrl_in;
        end
    end

endmodule

// File: tb/tb_dma_cfg_master.sv
// Self-checking bench for dma_cfg_master with a behavioural register responder.
// The model expands each job into its cycle-by-cycle bus timeline from the
// job parameters and the number of zero status reads; a compare process
// checks every cycle against that timeline (or against idle when no job).
// Build with DMA_CFG_TIMEOUT_EN to exercise the poll timeout.
module tb_dma_cfg_master;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned GAP   = 4;
    localparam int unsigned LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] io_in, mem_in, ctrl_in;
    logic          busy, done, error;
    logic [DW-1:0] intr_status;

    always #5 clk = ~clk;

    dma_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    dma_cfg_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_GAP(GAP), .POLL_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .io_addr_in(io_in), .mem_addr_in(mem_in), .ctrl_in(ctrl_in),
        .busy(busy), .done(done), .error(error), .intr_status(intr_status),
        .bus(bus_if)
    );

    // Responder: registered read data, clear-on-write status, bench override
    logic [31:0] resp_intr = '0;
    logic        set_req = 1'b0;
    logic [31:0] set_val = '0;

    always @(posedge clk) begin
        if (bus_if.valid && !bus_if.wr_en) bus_if.rdata <= resp_intr;
        if (set_req)
            resp_intr <= set_val;
        else if (bus_if.valid && bus_if.wr_en && bus_if.addr == 32'h400)
            resp_intr <= bus_if.wdata;
    end

    // ---------------- model ----------------
    typedef struct {
        logic        valid;
        logic        wr_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
        logic        error;
        logic [31:0] intr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_addr = '0, m_wdata = '0, m_intr = '0;
    logic        m_wr = 1'b0;

    int total = 0, bad = 0;
    int cyc = 0, n_reads = 0, n_clears = 0, n_dones = 0;
    int read_cyc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_cycle(input logic v, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic dn, input logic er);
        exp_t e;
        if (v) begin
            m_addr  = a;
            m_wr    = w;
            m_wdata = d;
        end
        e.valid = v;   e.wr_en = m_wr;  e.addr = m_addr; e.wdata = m_wdata;
        e.busy  = 1'b1; e.done = dn;    e.error = er;    e.intr = m_intr;
        exp_q.push_back(e);
    endtask

    // Whole-job timeline: three writes, polls separated by RD_WAIT plus GAP
    // idle cycles, then clear + finish (or finish with error on timeout).
    task automatic plan_job(input logic [31:0] io, input logic [31:0] mem,
                            input logic [31:0] ctrl, input int zeros,
                            input logic [31:0] status);
        int reads;
        bit to;
`ifdef DMA_CFG_TIMEOUT_EN
        to = (zeros >= int'(LIMIT));
`else
        to = 1'b0;
`endif
        reads = to ? int'(LIMIT) : zeros + 1;
        push_cycle(1'b1, 1'b1, 32'h408, io,   1'b0, 1'b0);
        push_cycle(1'b1, 1'b1, 32'h40C, mem,  1'b0, 1'b0);
        push_cycle(1'b1, 1'b1, 32'h404, ctrl, 1'b0, 1'b0);
        for (int r = 0; r < reads; r++) begin
            push_cycle(1'b1, 1'b0, 32'h400, m_wdata, 1'b0, 1'b0);
            push_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            if (r < reads - 1)
                for (int g = 0; g < int'(GAP); g++)
                    push_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        if (to) begin
            push_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        end else begin
            m_intr = status;
            push_cycle(1'b1, 1'b1, 32'h400, 32'h0, 1'b0, 1'b0);
            push_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    // Per-cycle compare, sampled 1 time unit after the rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.valid = 1'b0; e.wr_en = m_wr;  e.addr  = m_addr; e.wdata = m_wdata;
                e.busy  = 1'b0; e.done  = 1'b0;  e.error = 1'b0;   e.intr  = m_intr;
            end
            total++;
            if (bus_if.valid !== e.valid || bus_if.wr_en !== e.wr_en ||
                bus_if.addr !== e.addr || bus_if.wdata !== e.wdata ||
                busy !== e.busy || done !== e.done || error !== e.error ||
                intr_status !== e.intr) begin
                bad++;
                $display("FAIL cycle %0d: got v=%b w=%b a=%h d=%h busy=%b done=%b err=%b intr=%h want v=%b w=%b a=%h d=%h busy=%b done=%b err=%b intr=%h",
                         cyc, bus_if.valid, bus_if.wr_en, bus_if.addr, bus_if.wdata, busy, done, error, intr_status,
                         e.valid, e.wr_en, e.addr, e.wdata, e.busy, e.done, e.error, e.intr);
            end
            if (bus_if.valid && !bus_if.wr_en) begin
                n_reads++;
                read_cyc.push_back(cyc);
            end
            if (bus_if.valid && bus_if.wr_en && bus_if.addr == 32'h400) n_clears++;
            if (done) n_dones++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_intr(input logic [31:0] v);
        @(negedge clk);
        set_req = 1'b1;
        set_val = v;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    task automatic begin_job(input logic [31:0] io, input logic [31:0] mem,
                             input logic [31:0] ctrl, input int zeros,
                             input logic [31:0] status);
        io_in   = io;
        mem_in  = mem;
        ctrl_in = ctrl;
        start   = 1'b1;
        plan_job(io, mem, ctrl, zeros, status);
    endtask

    // Steps negedges after the start cycle until done; k = cycle of done.
    // Optionally re-pulses start at cycle pulse_at and loads the responder
    // status once set_after reads of this job have been seen.
    task automatic run_until_done(input int pulse_at, input int set_after,
                                  input logic [31:0] set_value, output int k);
        int  base;
        bit  set_done;
        base     = n_reads;
        set_done = 1'b0;
        k        = 0;
        do begin
            @(negedge clk);
            k++;
            start   = (k == pulse_at);
            set_req = 1'b0;
            if (!set_done && set_after >= 0 && (n_reads - base) == set_after) begin
                set_req  = 1'b1;
                set_val  = set_value;
                set_done = 1'b1;
            end
        end while (done !== 1'b1 && k < 400);
        start   = 1'b0;
        set_req = 1'b0;
        chk("done_seen", 32'(done), 32'h1);
    endtask

    initial begin
        int k, rb, cb, db, n;
        start = 1'b0; io_in = '0; mem_in = '0; ctrl_in = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 32'(bus_if.valid), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_addr",  bus_if.addr, 32'h0);
        chk("rst_wdata", bus_if.wdata, 32'h0);
        chk("rst_intr",  intr_status, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Job with status already set: done in cycle 7
        set_intr(32'h1);
        rb = n_reads; cb = n_clears;
        @(negedge clk);
        begin_job(32'h1000, 32'h2000, 32'h1, 0, 32'h1);
        chk("plan_len", 32'(exp_q.size()), 32'd7);
        run_until_done(-1, -1, 32'h0, k);
        chk("t1_done_cycle", 32'(k), 32'd7);
        chk("t1_reads", 32'(n_reads - rb), 32'd1);
        chk("t1_clears", 32'(n_clears - cb), 32'd1);
        @(negedge clk);
        chk("t1_intr", intr_status, 32'h1);

        // Status appears after the 3rd poll
        rb = n_reads;
        @(negedge clk);
        begin_job(32'hA0, 32'hB0, 32'hC0, 3, 32'h5);
        run_until_done(-1, 3, 32'h5, k);
        chk("t2_reads", 32'(n_reads - rb), 32'd4);
        n = read_cyc.size();
        for (int i = 1; i < 4; i++)
            chk("t2_read_spacing", 32'(read_cyc[n-4+i] - read_cyc[n-5+i]), 32'd6);
        @(negedge clk);
        chk("t2_intr", intr_status, 32'h5);

        // start while busy and in the done cycle: one job only
        set_intr(32'h2);
        db = n_dones;
        @(negedge clk);
        begin_job(32'h11, 32'h22, 32'h33, 0, 32'h2);
        run_until_done(3, -1, 32'h0, k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_dones", 32'(n_dones - db), 32'd1);
        chk("t3_idle_busy", 32'(busy), 32'h0);

        // start in the cycle right after done is accepted
        set_intr(32'h4);
        @(negedge clk);
        begin_job(32'h44, 32'h55, 32'h66, 0, 32'h4);
        run_until_done(-1, -1, 32'h0, k);
        set_req = 1'b1;
        set_val = 32'h6;
        @(negedge clk);
        set_req = 1'b0;
        begin_job(32'h77, 32'h88, 32'h99, 0, 32'h6);
        run_until_done(-1, -1, 32'h0, k);
        chk("t4_done_cycle", 32'(k), 32'd7);
        @(negedge clk);
        chk("t4_intr", intr_status, 32'h6);

        // Reset during WR_MEM abandons the job
        set_intr(32'h7);
        rb = n_reads;
        @(negedge clk);
        begin_job(32'h123, 32'h456, 32'h789, 0, 32'h7);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        chk("t5_in_wr_mem", bus_if.addr, 32'h40C);
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(bus_if.valid), 32'h0);
        chk("t5_rst_busy",  32'(busy), 32'h0);
        chk("t5_rst_addr",  bus_if.addr, 32'h0);
        chk("t5_rst_intr",  intr_status, 32'h0);
        exp_q.delete();
        m_addr = '0; m_wdata = '0; m_wr = 1'b0; m_intr = '0;
        repeat (2) @(negedge clk);
        chk("t5_no_reads", 32'(n_reads - rb), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        begin_job(32'hABC, 32'hDEF, 32'h5, 0, 32'h7);
        run_until_done(-1, -1, 32'h0, k);
        chk("t5_done_cycle", 32'(k), 32'd7);

`ifdef DMA_CFG_TIMEOUT_EN
        // Status stuck at zero: timeout after LIMIT reads, no clear
        rb = n_reads; cb = n_clears;
        @(negedge clk);
        begin_job(32'h1, 32'h2, 32'h3, int'(LIMIT), 32'h0);
        run_until_done(-1, -1, 32'h0, k);
        chk("t6_error", 32'(error), 32'h1);
        chk("t6_reads", 32'(n_reads - rb), 32'd8);
        chk("t6_clears", 32'(n_clears - cb), 32'd0);
`else
        // Long poll without timeout: completes after the 10th read
        rb = n_reads;
        @(negedge clk);
        begin_job(32'h1, 32'h2, 32'h3, 9, 32'h9);
        run_until_done(-1, 9, 32'h9, k);
        chk("t6_reads", 32'(n_reads - rb), 32'd10);
        chk("t6_error", 32'(error), 32'h0);
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
